// File: rtl/tall_skinny_matmul_stream.sv
// Streaming C = A x B engine: B (K x N) held on-chip, A streamed row by row.
// N MAC lanes, one C row per K A elements. Optional clamp: TSMM_RELU_EN.
module tall_skinny_matmul_stream #(
  parameter int DATA_W = 16,
  parameter int K      = 4,
  parameter int N      = 4,
  parameter int ROW_W  = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        b_valid,
  input  logic [DATA_W-1:0]                           b_data,
  output logic                                        b_ready,
  input  logic                                        b_reload,
  input  logic                                        a_valid,
  input  logic [DATA_W-1:0]                           a_data,
  output logic                                        a_ready,
  output logic                                        c_valid,
  output logic [N*(2*DATA_W+$clog2(K))-1:0]           c_data,
  output logic [ROW_W-1:0]                            c_row,
  input  logic                                        c_ready
);

  localparam int ACC_W = 2*DATA_W + $clog2(K);
  localparam int PW    = 2*DATA_W;
  localparam int BN    = K*N;
  localparam int BCW   = $clog2(BN);
  localparam int KW    = $clog2(K);

  localparam logic [BCW-1:0] B_LAST = BCW'(BN-1);
  localparam logic [KW-1:0]  K_LAST = KW'(K-1);

  typedef enum logic {
    LOAD_B = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BCW-1:0]   b_cnt;
  logic [KW-1:0]    k_cnt;
  logic [ROW_W-1:0] row_q;

  logic signed [DATA_W-1:0] b_mem [BN];
  logic signed [DATA_W-1:0] b_col [N];
  logic signed [ACC_W-1:0]  acc   [N];
  logic signed [PW-1:0]     prod  [N];
  logic signed [ACC_W-1:0]  term  [N];
  logic signed [ACC_W-1:0]  sum   [N];
  logic [N*ACC_W-1:0]       res;

  logic b_acc;
  logic a_acc;
  logic k_last;
  logic b_last;
  logic fire;

  assign b_acc  = b_valid && b_ready;
  assign a_acc  = a_valid && a_ready;
  assign k_last = (k_cnt == K_LAST);
  assign b_last = (b_cnt == B_LAST);
  assign fire   = a_acc && k_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_B;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD_B: begin
        if (b_acc && b_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Reload only between rows, and only on an idle A cycle
        if (b_reload && (k_cnt == '0) && !a_acc) begin
          state_d = LOAD_B;
        end
      end
      default: state_d = LOAD_B;
    endcase
  end

  always_comb begin
    b_ready = 1'b0;
    a_ready = 1'b0;
    unique case (state_q)
      LOAD_B: b_ready = 1'b1;
      RUN:    a_ready = !(k_last && c_valid && !c_ready);
      default: begin
        b_ready = 1'b0;
        a_ready = 1'b0;
      end
    endcase
  end

  // Row-major words shift in; after K*N accepts b_mem[i] holds word i
  always_ff @(posedge clk) begin
    if (rst) begin
      b_cnt <= '0;
      for (int i = 0; i < BN; i++) begin
        b_mem[i] <= '0;
      end
    end else if (b_acc) begin
      for (int i = 0; i < BN-1; i++) begin
        b_mem[i] <= b_mem[i+1];
      end
      b_mem[BN-1] <= $signed(b_data);
      b_cnt <= b_last ? '0 : b_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int n = 0; n < N; n++) begin
      b_col[n] = '0;
      for (int k = 0; k < K; k++) begin
        if (k_cnt == KW'(k)) begin
          b_col[n] = b_mem[k*N+n];
        end
      end
    end
  end

  always_comb begin
    res = '0;
    for (int n = 0; n < N; n++) begin
      prod[n] = $signed(a_data) * b_col[n];
      term[n] = {{(ACC_W-PW){prod[n][PW-1]}}, prod[n]};
      sum[n]  = acc[n] + term[n];
`ifdef TSMM_RELU_EN
      res[n*ACC_W +: ACC_W] = sum[n][ACC_W-1] ? '0 : sum[n];
`else
      res[n*ACC_W +: ACC_W] = sum[n];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_cnt <= '0;
      for (int n = 0; n < N; n++) begin
        acc[n] <= '0;
      end
    end else if (a_acc) begin
      k_cnt <= k_last ? '0 : k_cnt + 1'b1;
      for (int n = 0; n < N; n++) begin
        acc[n] <= (k_cnt == '0) ? term[n] : sum[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
    end else if (b_acc && b_last) begin
      row_q <= '0;
    end else if (fire) begin
      row_q <= row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_data  <= '0;
      c_row   <= '0;
    end else if (fire) begin
      c_valid <= 1'b1;
      c_data  <= res;
      c_row   <= row_q;
    end else if (c_ready) begin
      c_valid <= 1'b0;
    end
  end

endmodule
